// File: rtl/trace_pkg.sv
// Shared types for the retire trace: record kinds, the trace record layout
// and the trace FSM states.
package trace_pkg;

    localparam int TRACE_INUM_W = 16;
    localparam int TRACE_CYC_W  = 32;

    typedef enum logic [2:0] {
        TK_NOP  = 3'd0,
        TK_REG  = 3'd1,
        TK_LD   = 3'd2,
        TK_STU  = 3'd3,
        TK_ST   = 3'd4,
        TK_HALT = 3'd5
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e             kind;
        logic [TRACE_INUM_W-1:0] inum;
        logic [15:0]             pc;
        logic [15:0]             inst;
        logic [2:0]              wreg;
        logic [15:0]             wdata;
        logic [15:0]             addr;
        logic [15:0]             mdata;
        logic [TRACE_CYC_W-1:0]  cyc;
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_DONE
    } trace_state_e;

    // Register-writing forms outrank halt, which outranks a plain store.
    function automatic trace_kind_e trace_classify(input logic reg_wrt, input logic mem_rd,
                                                   input logic mem_wr, input logic halt);
        if (reg_wrt && mem_wr)      return TK_STU;
        else if (reg_wrt && mem_rd) return TK_LD;
        else if (reg_wrt)           return TK_REG;
        else if (halt)              return TK_HALT;
        else if (mem_wr)            return TK_ST;
        else                        return TK_NOP;
    endfunction

endpackage

// File: rtl/retire_trace_if.sv
// Retire-stage sampling bus plus the valid/ready trace record port.
interface retire_trace_if;
    import trace_pkg::*;

    logic        ret_vld;
    logic [15:0] ret_pc;
    logic [15:0] ret_inst;
    logic        ret_reg_wrt;
    logic [2:0]  ret_wr_reg;
    logic [15:0] ret_wr_data;
    logic        ret_mem_rd;
    logic        ret_mem_wr;
    logic [15:0] ret_mem_addr;
    logic [15:0] ret_mem_data;
    logic        ret_halt;
    logic        rec_vld;
    logic        rec_rdy;
    trace_rec_t  rec;
    logic        full;
    logic        ovf;
    logic        done;

    modport master (
        output ret_vld, ret_pc, ret_inst, ret_reg_wrt, ret_wr_reg, ret_wr_data,
               ret_mem_rd, ret_mem_wr, ret_mem_addr, ret_mem_data, ret_halt, rec_rdy,
        input  rec_vld, rec, full, ovf, done
    );

    modport slave (
        input  ret_vld, ret_pc, ret_inst, ret_reg_wrt, ret_wr_reg, ret_wr_data,
               ret_mem_rd, ret_mem_wr, ret_mem_addr, ret_mem_data, ret_halt, rec_rdy,
        output rec_vld, rec, full, ovf, done
    );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous record FIFO: wrapping pointers plus an occupancy count, registered
// full flag, and a head that reads as all-zero while empty.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  trace_rec_t push_data,
    input  logic       pop,
    output trace_rec_t head,
    output logic       empty,
    output logic       full,
    output logic       empty_nxt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    trace_rec_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q;

    always_comb begin
        // NOTE: defaults first so every path assigns every _d signal and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_CNT);
        end
    end

    // NOTE: storage is deliberately not reset; the count guards every read of it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign empty     = (count_q == '0);
    assign empty_nxt = (count_d == '0);
    assign full      = full_q;
    assign head      = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/retire_trace.sv
// Retire-stage commit trace: classifies retirements, stamps them and queues them.
// Optional cycle stamping is built when TRACE_CYCLE_EN is defined.
module retire_trace
    import trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int INUM_W = 16,
    parameter int CYC_W  = 32
) (
    input logic           clk,
    input logic           rst_n,
    retire_trace_if.slave tif
);

    trace_state_e      state_q, state_d;
    logic [INUM_W-1:0] inum_q, inum_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [CYC_W-1:0]  cyc_cap;

    trace_rec_t new_rec, head;
    logic       fifo_empty, fifo_full, fifo_empty_nxt;
    logic       retire, push, pop, drop;

    assign pop    = !fifo_empty && tif.rec_rdy;
    assign retire = tif.ret_vld && (state_q == ST_RUN);
    assign push   = retire && (!fifo_full || pop);
    assign drop   = retire && fifo_full && !pop;

`ifdef TRACE_CYCLE_EN
    logic [CYC_W-1:0] cyc_q, cyc_d;

    always_comb cyc_d = cyc_q + CYC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign cyc_cap = cyc_q;
`else
    assign cyc_cap = '0;
`endif

    // Fields irrelevant to the kind stay zero so consumers can compare records whole.
    always_comb begin
        new_rec      = '0;
        new_rec.kind = trace_classify(tif.ret_reg_wrt, tif.ret_mem_rd, tif.ret_mem_wr, tif.ret_halt);
        new_rec.inum = TRACE_INUM_W'(inum_q);
        new_rec.pc   = tif.ret_pc;
        new_rec.inst = tif.ret_inst;
        new_rec.cyc  = TRACE_CYC_W'(cyc_cap);
        case (new_rec.kind)
            TK_STU, TK_LD, TK_REG: begin
                new_rec.wreg  = tif.ret_wr_reg;
                new_rec.wdata = tif.ret_wr_data;
            end
            default: ;
        endcase
        if (new_rec.kind inside {TK_STU, TK_LD, TK_ST}) new_rec.addr  = tif.ret_mem_addr;
        if (new_rec.kind inside {TK_STU, TK_ST})        new_rec.mdata = tif.ret_mem_data;
    end

    always_comb begin
        state_d = state_q;
        inum_d  = inum_q + INUM_W'(retire);
        ovf_d   = ovf_q || drop;
        case (state_q)
            ST_RUN:    if (retire && tif.ret_halt) state_d = ST_HALTED;
            ST_HALTED: if (fifo_empty_nxt)         state_d = ST_DONE;
            default:   state_d = ST_DONE;
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            inum_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inum_q  <= inum_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (new_rec),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .empty_nxt (fifo_empty_nxt)
    );

    assign tif.rec_vld = !fifo_empty;
    assign tif.rec     = head;
    assign tif.full    = fifo_full;
    assign tif.ovf     = ovf_q;
    assign tif.done    = done_q;

endmodule

// File: tb/tb_retire_trace.sv
// Directed bench for retire_trace: classification, stamping, overflow, halt/done
// and asynchronous reset, with hand-computed expected records.
module tb_retire_trace;
    import trace_pkg::*;

    localparam int DEPTH = 8;
`ifdef TRACE_CYCLE_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    retire_trace_if tif ();

    retire_trace #(.DEPTH(DEPTH), .INUM_W(16), .CYC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tif   (tif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tif.ret_vld      = 1'b0;
        tif.ret_pc       = '0;
        tif.ret_inst     = '0;
        tif.ret_reg_wrt  = 1'b0;
        tif.ret_wr_reg   = '0;
        tif.ret_wr_data  = '0;
        tif.ret_mem_rd   = 1'b0;
        tif.ret_mem_wr   = 1'b0;
        tif.ret_mem_addr = '0;
        tif.ret_mem_data = '0;
        tif.ret_halt     = 1'b0;
    endtask

    task automatic retire(input logic rw, input logic mr, input logic mw, input logic hl,
                          input logic [2:0] r, input logic [15:0] pc, input logic [15:0] inst,
                          input logic [15:0] wd, input logic [15:0] ad, input logic [15:0] md);
        tif.ret_vld      = 1'b1;
        tif.ret_reg_wrt  = rw;
        tif.ret_mem_rd   = mr;
        tif.ret_mem_wr   = mw;
        tif.ret_halt     = hl;
        tif.ret_wr_reg   = r;
        tif.ret_pc       = pc;
        tif.ret_inst     = inst;
        tif.ret_wr_data  = wd;
        tif.ret_mem_addr = ad;
        tif.ret_mem_data = md;
    endtask

    // Register write whose fields are derived from an index, so drains can re-derive them.
    task automatic retire_reg(input int i);
        retire(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'(i * 2), 16'(16'h4000 + i), 16'(i), 16'h0077, 16'h0088);
    endtask

    task automatic check_rec(input string tag, input trace_kind_e kind, input logic [15:0] inum,
                             input logic [15:0] pc, input logic [15:0] inst, input logic [2:0] r,
                             input logic [15:0] wd, input logic [15:0] ad, input logic [15:0] md);
        check({tag, ".vld"},   32'(tif.rec_vld),    32'd1);
        check({tag, ".kind"},  32'(tif.rec.kind),   32'(kind));
        check({tag, ".inum"},  32'(tif.rec.inum),   32'(inum));
        check({tag, ".pc"},    32'(tif.rec.pc),     32'(pc));
        check({tag, ".inst"},  32'(tif.rec.inst),   32'(inst));
        check({tag, ".reg"},   32'(tif.rec.wreg),   32'(r));
        check({tag, ".wdata"}, 32'(tif.rec.wdata),  32'(wd));
        check({tag, ".addr"},  32'(tif.rec.addr),   32'(ad));
        check({tag, ".mdata"}, 32'(tif.rec.mdata),  32'(md));
    endtask

    task automatic check_reg_rec(input string tag, input int i);
        check_rec(tag, TK_REG, 16'(i), 16'(i * 2), 16'(16'h4000 + i), 3'd1, 16'(i), 16'h0000, 16'h0000);
    endtask

    // Asserts reset mid-cycle, checks outputs drop at once, releases on a falling edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, ".rst_vld"},  32'(tif.rec_vld), 32'd0);
        check({tag, ".rst_full"}, 32'(tif.full),    32'd0);
        check({tag, ".rst_ovf"},  32'(tif.ovf),     32'd0);
        check({tag, ".rst_done"}, 32'(tif.done),    32'd0);
        check({tag, ".rst_rec"},  32'(|tif.rec),    32'd0);
        idle();
        tif.rec_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        tif.rec_rdy = 1'b0;
        idle();
        #1;
        do_reset("init");

        // Single register write, consumer ready.
        tif.rec_rdy = 1'b1;
        retire(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h0002, 16'hC3A1, 16'h1234, 16'h0077, 16'h0088);
        tick();
        idle();
        check_rec("t1", TK_REG, 16'd0, 16'h0002, 16'hC3A1, 3'd3, 16'h1234, 16'h0000, 16'h0000);
        check("t1.cyc", tif.rec.cyc, 32'd0);
        tick();
        check("t1.empty", 32'(tif.rec_vld), 32'd0);

        // LD, STU, ST, NOP queued, then drained.
        do_reset("t2");
        retire(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0010, 16'h8A40, 16'h00AA, 16'h0040, 16'h3333);
        tick();
        retire(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0012, 16'h9B20, 16'h0042, 16'h0020, 16'h1111);
        tick();
        retire(1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 16'h0014, 16'h8C10, 16'h5555, 16'h0010, 16'hBEEF);
        tick();
        retire(1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 16'h0016, 16'h0800, 16'h7777, 16'h0099, 16'h4444);
        tick();
        idle();
        tif.rec_rdy = 1'b1;
        check_rec("t2.ld",  TK_LD,  16'd0, 16'h0010, 16'h8A40, 3'd5, 16'h00AA, 16'h0040, 16'h0000);
        tick();
        check_rec("t2.stu", TK_STU, 16'd1, 16'h0012, 16'h9B20, 3'd2, 16'h0042, 16'h0020, 16'h1111);
        tick();
        check_rec("t2.st",  TK_ST,  16'd2, 16'h0014, 16'h8C10, 3'd0, 16'h0000, 16'h0010, 16'hBEEF);
        tick();
        check_rec("t2.nop", TK_NOP, 16'd3, 16'h0016, 16'h0800, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        tick();
        check("t2.empty", 32'(tif.rec_vld), 32'd0);

        // DEPTH+2 retirements with the consumer stalled: two drops, inum gap.
        do_reset("t3");
        for (int i = 0; i < DEPTH + 2; i++) begin
            retire_reg(i);
            tick();
            if (i == DEPTH - 2) check("t3.not_full", 32'(tif.full), 32'd0);
            if (i == DEPTH - 1) begin
                check("t3.full", 32'(tif.full), 32'd1);
                check("t3.no_ovf", 32'(tif.ovf), 32'd0);
            end
        end
        idle();
        check("t3.full_end", 32'(tif.full), 32'd1);
        check("t3.ovf", 32'(tif.ovf), 32'd1);
        tif.rec_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check_reg_rec($sformatf("t3.drain%0d", i), i);
            tick();
        end
        check("t3.drained", 32'(tif.rec_vld), 32'd0);
        check("t3.full_clr", 32'(tif.full), 32'd0);
        check("t3.ovf_sticky", 32'(tif.ovf), 32'd1);
        retire_reg(DEPTH + 2);
        tick();
        idle();
        check_reg_rec("t3.after", DEPTH + 2);
        tick();

        // Push and pop in the same cycle while full.
        do_reset("t4");
        for (int i = 0; i < DEPTH; i++) begin
            retire_reg(i);
            tick();
        end
        check("t4.full", 32'(tif.full), 32'd1);
        retire_reg(DEPTH);
        tif.rec_rdy = 1'b1;
        tick();
        idle();
        tif.rec_rdy = 1'b0;
        check("t4.full_kept", 32'(tif.full), 32'd1);
        check("t4.no_ovf", 32'(tif.ovf), 32'd0);
        tif.rec_rdy = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            check_reg_rec($sformatf("t4.drain%0d", i), i);
            tick();
        end
        check("t4.drained", 32'(tif.rec_vld), 32'd0);

        // HALT behind three queued records, then further retirements ignored.
        do_reset("t5");
        for (int i = 0; i < 3; i++) begin
            retire_reg(i);
            tick();
        end
        retire(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0100, 16'h0000, 16'h2222, 16'h0055, 16'h0066);
        tif.rec_rdy = 1'b1;
        tick();
        retire_reg(20);
        check_reg_rec("t5.q1", 1);
        check("t5.done_q1", 32'(tif.done), 32'd0);
        tick();
        check_reg_rec("t5.q2", 2);
        tick();
        check_rec("t5.halt", TK_HALT, 16'd3, 16'h0100, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        check("t5.done_halt", 32'(tif.done), 32'd0);
        tick();
        check("t5.vld_end", 32'(tif.rec_vld), 32'd0);
        check("t5.done", 32'(tif.done), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t5.ignored%0d", k), 32'(tif.rec_vld), 32'd0);
            check($sformatf("t5.done_hold%0d", k), 32'(tif.done), 32'd1);
        end
        idle();

        // Reset with five queued, then inum restart and cycle stamps.
        do_reset("t6a");
        for (int i = 0; i < 5; i++) begin
            retire_reg(i + 8);
            tick();
        end
        idle();
        check("t6.queued", 32'(tif.rec_vld), 32'd1);
        do_reset("t6b");
        for (int i = 0; i < 4; i++) begin
            retire_reg(i);
            tick();
        end
        idle();
        tif.rec_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_reg_rec($sformatf("t6.rec%0d", i), i);
            check($sformatf("t6.cyc%0d", i), tif.rec.cyc, CYC_EN ? 32'(i) : 32'd0);
            tick();
        end
        check("t6.drained", 32'(tif.rec_vld), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
